// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch: FSM states,
// BCD digit pairs and the wrap limits of each field.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int unsigned CS_MAX  = 99;
    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
    } bcd2_t;

    typedef struct packed {
        bcd2_t min;
        bcd2_t sec;
        bcd2_t cs;
    } sw_time_t;

    function automatic bcd2_t bcd2_inc(input bcd2_t v);
        bcd2_t r;
        if (v.lo == 4'd9) begin
            r.lo = 4'd0;
            r.hi = v.hi + 4'd1;
        end else begin
            r.lo = v.lo + 4'd1;
            r.hi = v.hi;
        end
        return r;
    endfunction

    function automatic logic bcd2_is_max(input bcd2_t v, input int unsigned lim);
        return (v.hi == 4'(lim / 10)) && (v.lo == 4'(lim % 10));
    endfunction

endpackage

// File: rtl/stopwatch_core_sync_rise.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
module sync_rise (
    input  logic MCLK,
    input  logic RESET_N,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/stopwatch_core.sv
// Centisecond stopwatch: synchronized 100 Hz tick, start/pause/clear FSM,
// BCD mm:ss.cc counter with lap freeze and a pause blink for the display.
module stopwatch_core
    import stopwatch_pkg::*;
(
    input  logic       MCLK,
    input  logic       RESET_N,
    input  logic       CLK1,
    input  logic       CLK2,
    input  logic       BTN_SS,
    input  logic       BTN_LAP,
    output logic [7:0] MIN_BCD,
    output logic [7:0] SEC_BCD,
    output logic [7:0] CS_BCD,
    output logic       RUNNING,
    output logic       LAP_ACTIVE,
    output logic       BLINK,
    output logic       OVERFLOW
);

    logic [2:0] w_async;
    logic [2:0] w_rise;
    logic       w_tick;
    logic       w_ss;
    logic       w_lap;

    assign w_async = {BTN_LAP, BTN_SS, CLK2};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            sync_rise u_sync (
                .MCLK    (MCLK),
                .RESET_N (RESET_N),
                .i_async (w_async[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    assign w_tick = w_rise[0];
    assign w_ss   = w_rise[1];
    assign w_lap  = w_rise[2];

    logic r_clk1_meta;
    logic r_clk1_sync;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_clk1_meta <= 1'b0;
            r_clk1_sync <= 1'b0;
        end else begin
            r_clk1_meta <= CLK1;
            r_clk1_sync <= r_clk1_meta;
        end
    end

    sw_state_t r_state;
    sw_state_t w_state_next;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Start/stop has priority; a lap pulse arriving with it is dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_ss) w_state_next = ST_RUN;
            ST_RUN:   if (w_ss) w_state_next = ST_PAUSE;
            ST_PAUSE: begin
                if (w_ss)       w_state_next = ST_RUN;
                else if (w_lap) w_state_next = ST_IDLE;
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        RUNNING = (r_state == ST_RUN);
        BLINK   = (r_state == ST_PAUSE) ? r_clk1_sync : 1'b1;
    end

    sw_time_t r_cnt;
    sw_time_t r_snap;
    sw_time_t w_cnt_next;
    sw_time_t w_snap_next;
    sw_time_t w_disp;
    logic     r_lap;
    logic     r_ovf;
    logic     w_lap_next;
    logic     w_ovf_next;
    logic     w_inc;
    logic     w_clear;
    logic     w_lap_toggle;
    logic     w_cs_wrap;
    logic     w_sec_wrap;
    logic     w_min_wrap;

    assign w_inc        = (r_state == ST_RUN) && w_tick;
    assign w_clear      = (r_state == ST_PAUSE) && w_lap && !w_ss;
    assign w_lap_toggle = (r_state == ST_RUN) && w_lap && !w_ss;
    assign w_cs_wrap    = bcd2_is_max(r_cnt.cs,  CS_MAX);
    assign w_sec_wrap   = bcd2_is_max(r_cnt.sec, SEC_MAX);
    assign w_min_wrap   = bcd2_is_max(r_cnt.min, MIN_MAX);

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_clear) begin
            w_cnt_next = '0;
        end else if (w_inc) begin
            w_cnt_next.cs = w_cs_wrap ? '0 : bcd2_inc(r_cnt.cs);
            if (w_cs_wrap) begin
                w_cnt_next.sec = w_sec_wrap ? '0 : bcd2_inc(r_cnt.sec);
                if (w_sec_wrap) begin
                    w_cnt_next.min = w_min_wrap ? '0 : bcd2_inc(r_cnt.min);
                end
            end
        end
    end

    always_comb begin
        w_ovf_next = r_ovf;
        if (w_clear) begin
            w_ovf_next = 1'b0;
        end else if (w_inc && w_cs_wrap && w_sec_wrap && w_min_wrap) begin
            w_ovf_next = 1'b1;
        end
    end

    // Snapshot captures the pre-increment count when a tick coincides.
    always_comb begin
        w_lap_next  = r_lap;
        w_snap_next = r_snap;
        if ((r_state == ST_RUN) && w_ss) begin
            w_lap_next = 1'b0;
        end else if (w_lap_toggle) begin
            w_lap_next = ~r_lap;
            if (!r_lap) w_snap_next = r_cnt;
        end else if (w_clear) begin
            w_lap_next = 1'b0;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt  <= '0;
            r_snap <= '0;
            r_lap  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_snap <= w_snap_next;
            r_lap  <= w_lap_next;
            r_ovf  <= w_ovf_next;
        end
    end

    assign w_disp     = r_lap ? r_snap : r_cnt;
    assign MIN_BCD    = w_disp.min;
    assign SEC_BCD    = w_disp.sec;
    assign CS_BCD     = w_disp.cs;
    assign LAP_ACTIVE = r_lap;
    assign OVERFLOW   = r_ovf;

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core: a centisecond-integer model predicts
// every display change and status level; a monitor checks display changes.
module tb_stopwatch_core;

    logic       MCLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       CLK1 = 1'b0;
    logic       CLK2 = 1'b0;
    logic       BTN_SS = 1'b0;
    logic       BTN_LAP = 1'b0;
    logic [7:0] MIN_BCD;
    logic [7:0] SEC_BCD;
    logic [7:0] CS_BCD;
    logic       RUNNING;
    logic       LAP_ACTIVE;
    logic       BLINK;
    logic       OVERFLOW;

    always #5 MCLK = ~MCLK;

    stopwatch_core dut (
        .MCLK       (MCLK),
        .RESET_N    (RESET_N),
        .CLK1       (CLK1),
        .CLK2       (CLK2),
        .BTN_SS     (BTN_SS),
        .BTN_LAP    (BTN_LAP),
        .MIN_BCD    (MIN_BCD),
        .SEC_BCD    (SEC_BCD),
        .CS_BCD     (CS_BCD),
        .RUNNING    (RUNNING),
        .LAP_ACTIVE (LAP_ACTIVE),
        .BLINK      (BLINK),
        .OVERFLOW   (OVERFLOW)
    );

    int vectors = 0;
    int miscompares = 0;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    int          m_st   = M_IDLE;
    int          m_cnt  = 0;
    int          m_snap = 0;
    bit          m_lap  = 1'b0;
    bit          m_ovf  = 1'b0;
    logic [23:0] m_last = 24'h0;
    logic [23:0] exp_q[$];

    function automatic logic [23:0] to_bcd(input int t);
        int mm, ss, cc;
        mm = t / 6000;
        ss = (t / 100) % 60;
        cc = t % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic logic [23:0] m_disp();
        return to_bcd(m_lap ? m_snap : m_cnt);
    endfunction

    task automatic m_publish();
        if (m_disp() !== m_last) begin
            m_last = m_disp();
            exp_q.push_back(m_last);
        end
    endtask

    task automatic m_reset();
        m_st = M_IDLE; m_cnt = 0; m_snap = 0; m_lap = 1'b0; m_ovf = 1'b0;
        m_publish();
    endtask

    // Button/tick rules applied to the state as it was before this event.
    task automatic m_event(input bit ss, input bit lap, input bit tick);
        int old_st;
        old_st = m_st;
        if (ss) begin
            if (m_st == M_IDLE)     m_st = M_RUN;
            else if (m_st == M_RUN) begin m_st = M_PAUSE; m_lap = 1'b0; end
            else                    m_st = M_RUN;
        end else if (lap) begin
            if (m_st == M_RUN) begin
                if (!m_lap) begin m_snap = m_cnt; m_lap = 1'b1; end
                else m_lap = 1'b0;
            end else if (m_st == M_PAUSE) begin
                m_st = M_IDLE; m_cnt = 0; m_ovf = 1'b0; m_lap = 1'b0;
            end
        end
        if (tick && old_st == M_RUN) begin
            m_cnt++;
            if (m_cnt == 360000) begin m_cnt = 0; m_ovf = 1'b1; end
        end
        m_publish();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name);
        chk({name, ".running"}, 32'(RUNNING), 32'(m_st == M_RUN));
        chk({name, ".lap"},     32'(LAP_ACTIVE), 32'(m_lap));
        chk({name, ".ovf"},     32'(OVERFLOW), 32'(m_ovf));
        chk({name, ".blink"},   32'(BLINK), (m_st == M_PAUSE) ? 32'(CLK1) : 32'd1);
    endtask

    task automatic check_disp(input string name);
        chk(name, 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'(m_disp()));
    endtask

    task automatic drive(input bit ss, input bit lap, input bit tick);
        @(negedge MCLK);
        m_event(ss, lap, tick);
        BTN_SS = ss; BTN_LAP = lap; CLK2 = tick;
        repeat (8) @(negedge MCLK);
        BTN_SS = 1'b0; BTN_LAP = 1'b0; CLK2 = 1'b0;
        repeat (8) @(negedge MCLK);
        if (ss || lap)
            $display("op ss=%0d lap=%0d tick=%0d -> state=%0d lap=%0d model=%06h",
                     ss, lap, tick, m_st, m_lap, m_disp());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1);
        $display("op ticks=%0d -> state=%0d model=%06h", n, m_st, m_disp());
    endtask

    // Monitor: every change of the displayed value consumes one prediction.
    logic [23:0] mon_last = 24'h0;
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge MCLK);
            if ({MIN_BCD, SEC_BCD, CS_BCD} !== mon_last) begin
                mon_last = {MIN_BCD, SEC_BCD, CS_BCD};
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL display_seq: got %06h, expected no change", mon_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("display_seq", 32'(mon_last), 32'(e));
                end
            end
        end
    end

    initial begin
        int op;
        m_reset();
        repeat (3) @(negedge MCLK);
        check_status("reset");
        check_disp("reset.disp");
        RESET_N = 1'b1;
        repeat (2) @(negedge MCLK);

        // Start latency: RUNNING rises at the third edge after BTN_SS is sampled.
        @(negedge MCLK);
        m_event(1'b1, 1'b0, 1'b0);
        BTN_SS = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge MCLK); #1;
            chk($sformatf("ss_latency.e%0d", i), 32'(RUNNING), 32'(i >= 4));
        end
        @(negedge MCLK); BTN_SS = 1'b0;
        repeat (8) @(negedge MCLK);

        @(negedge MCLK);
        m_event(1'b0, 1'b0, 1'b1);
        CLK2 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge MCLK); #1;
            chk($sformatf("tick_latency.e%0d", i), 32'(CS_BCD), (i >= 4) ? 32'h01 : 32'h00);
        end
        repeat (4) @(negedge MCLK); CLK2 = 1'b0;
        repeat (8) @(negedge MCLK);

        ticks(249);
        chk("run_250", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000250);
        check_status("run_250");

        ticks(250);
        chk("run_500", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000500);
        drive(1'b0, 1'b1, 1'b0);
        ticks(100);
        chk("lap_frozen", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000500);
        check_status("lap_frozen");
        drive(1'b0, 1'b1, 1'b0);
        chk("lap_release", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000600);
        check_status("lap_release");

        for (int n = 0; n < 30; n++) begin
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1, 2: ticks(int'($urandom_range(1, 25)));
                3:       drive(1'b1, 1'b0, 1'b0);
                4:       drive(1'b0, 1'b1, 1'b0);
                default: drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            endcase
            check_status("rand");
            check_disp("rand.disp");
        end

        for (int i = 0; i < 3; i++) if (m_st != M_PAUSE) drive(1'b1, 1'b0, 1'b0);
        @(negedge MCLK);
        m_cnt = 359999;
        m_publish();
        force dut.r_cnt = 24'h595999;
        repeat (2) @(negedge MCLK);
        release dut.r_cnt;
        repeat (2) @(negedge MCLK);
        chk("preload", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h595999);
        drive(1'b1, 1'b0, 1'b0);
        ticks(1);
        chk("wrap", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000000);
        chk("wrap.ovf", 32'(OVERFLOW), 32'd1);
        check_status("wrap");
        ticks(1);
        check_status("ovf_sticky");
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        chk("clear", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000000);
        chk("clear.ovf", 32'(OVERFLOW), 32'd0);
        check_status("clear");

        drive(1'b1, 1'b0, 1'b0);
        ticks(37);
        drive(1'b0, 1'b1, 1'b0);
        ticks(5);
        drive(1'b1, 1'b1, 1'b0);
        chk("ss_lap_same.lap", 32'(LAP_ACTIVE), 32'd0);
        chk("ss_lap_same.disp", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000042);
        check_status("ss_lap_same");

        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        chk("tick_at_pause", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000043);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        chk("tick_at_start", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000000);
        ticks(3);
        drive(1'b0, 1'b1, 1'b1);
        chk("tick_at_freeze", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000003);
        drive(1'b0, 1'b1, 1'b0);
        check_disp("unfreeze");

        drive(1'b1, 1'b0, 1'b0);
        @(negedge MCLK); CLK1 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge MCLK); #1;
            chk($sformatf("blink_rise.e%0d", i), 32'(BLINK), 32'(i >= 2));
        end
        @(negedge MCLK); CLK1 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge MCLK); #1;
            chk($sformatf("blink_fall.e%0d", i), 32'(BLINK), 32'(i < 2));
        end
        drive(1'b1, 1'b0, 1'b0);
        @(negedge MCLK); CLK1 = 1'b1;
        repeat (4) @(negedge MCLK);
        chk("blink_run", 32'(BLINK), 32'd1);
        CLK1 = 1'b0;

        ticks(343);
        chk("pre_reset", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000347);
        @(negedge MCLK);
        m_reset();
        RESET_N = 1'b0;
        #1;
        chk("async_reset.disp", 32'({MIN_BCD, SEC_BCD, CS_BCD}), 32'h000000);
        check_status("async_reset");
        repeat (3) @(negedge MCLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge MCLK);
        drive(1'b0, 1'b1, 1'b0);
        ticks(2);
        chk("lap_in_idle.running", 32'(RUNNING), 32'd0);
        check_disp("lap_in_idle.disp");

        repeat (10) @(negedge MCLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
